serial_accum_ctrl: RTL and testbench
====================================

# serial_accum_ctrl

Sequencing controller for the team's 4-bit add/subtract datapath. It accepts add/subtract requests on a valid/ready handshake and runs each one bit-serially, LSB first, through a single shared one-bit full-adder cell. The result is committed to an accumulator register that drives the existing segment display converter. It replaces the parallel ripple chain wherever area matters more than latency.

## Interface
- `WIDTH`, default 4: operand and accumulator width in bits; must be ≥2.
- `DIGIT_MAX`, default 9: largest accumulator value shown as a single decimal digit.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `op_valid` in 1: request present.
- `op_ready` out 1: controller can accept a request this cycle.
- `op_sub` in 1: 0 means acc + op_b; 1 means acc − op_b.
- `op_b` in WIDTH: operand, sampled only on the accepting edge.
- `clear` in 1: synchronous accumulator clear, honoured only in IDLE.
- `busy` out 1: a serial operation is in progress (state CALC).
- `result_valid` out 1: one-cycle pulse; the new `acc` and `ovf` values are valid.
- `acc` out WIDTH: committed accumulator value.
- `ovf` out 1: carry-out of the last add, or borrow of the last subtract.
- `dec_err` out 1: `acc` > DIGIT_MAX; combinational from `acc`.

## Operation
- States:
  - IDLE: `op_ready` = !`clear`.
  - CALC: runs WIDTH cycles.
  - DONE: lasts 1 cycle.
- In IDLE with `clear`=1:
  - acc←0, ovf←0.
  - `op_valid` is ignored that cycle; `clear` has priority.
- In IDLE, the handshake is `op_valid` && `op_ready`. On the accepting edge:
  - Load the working register W←acc and the operand register B←(op_sub ? ~op_b : op_b).
  - Load carry←op_sub, so subtraction is two's complement via carry-in 1.
  - Load bit counter←0 and latch op_sub.
  - Go to CALC.
- Each CALC edge:
  - s,c = FA(W[0], B[0], carry).
  - W←{s, W[WIDTH-1:1]}, B←B>>1, carry←c, counter+1.
- On the edge where counter = WIDTH−1:
  - Commit acc←final W, including the last shifted-in bit.
  - ovf←(sub ? ~carry_out : carry_out).
  - Go to DONE.
- DONE: `result_valid`=1 and `op_ready`=0; next edge returns to IDLE.
- `acc` holds its previous value throughout CALC. No partial results are visible.
- Arithmetic is modulo 2^WIDTH. ovf never blocks the commit.
- `op_valid`, `op_b`, `op_sub` and `clear` are ignored outside IDLE. A requester holding `op_valid` waits for the next IDLE.

## Timing
- Reset (async, immediate):
  - State IDLE; acc=0, ovf=0, W=0, B=0, counter=0, carry=0.
  - Outputs: `busy`=0, `result_valid`=0, `dec_err`=0. `op_ready`=1 unless `clear` is high.
- Reset asserted mid-CALC or in DONE aborts the operation: no `result_valid` pulse, and acc reads 0.
- Latency, with the accept on edge E0:
  - CALC spans edges E1..E_WIDTH; acc is updated on E_WIDTH.
  - `result_valid` is high during the cycle after E_WIDTH.
  - IDLE is re-entered at E_WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. For WIDTH=4, back-to-back accepts are 6 cycles apart.
- `dec_err` follows `acc` combinationally, so it changes in the same cycle `result_valid` rises.
- `busy`, `op_ready` and `result_valid` are decoded from registered state only, with no input-to-output path, except `op_ready`'s dependence on `clear`.

## Structure
- Shared package `calc_pkg`:
  - State enum: IDLE, CALC, DONE.
  - Default WIDTH and DIGIT_MAX.
  - Op encoding constants OP_ADD=0 and OP_SUB=1.
  - Counter width, computed as clog2(WIDTH).
- Sub-module `fa_cell`: combinational one-bit full adder (a, b, cin → s, cout). Instantiated exactly once in the controller.
- All registers live in the top-level controller. There is no clock gating.

## Test plan
- Reset, then add 5 to 0: `result_valid` goes high in the cycle after edge E4; acc=5, ovf=0, dec_err=0. `busy` is high for exactly 4 cycles.
- acc=9, add 8: acc=1, ovf=1, dec_err=0. Then clear, and from acc=9 add 3: acc=12, ovf=0, dec_err=1.
- acc=3, subtract 5: acc=14, ovf=1 (borrow). Then acc=7, subtract 2: acc=5, ovf=0. Subtract 0 from 0: acc=0, ovf=0.
- Hold `op_valid`=1 while changing `op_b` every cycle: accepts occur every 6 cycles. Each result uses the op_b sampled on its accept edge, and acc is unchanged during CALC.
- In IDLE, assert `clear` and `op_valid` (add 4) in the same cycle: acc=0, no accept. The add is accepted next cycle, giving acc=4.
- Assert `rst_n`=0 on the 2nd CALC cycle of an add of 6 onto acc=3: immediately acc=0, busy=0, IDLE. No `result_valid` pulse follows.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
// Holds the FSM state encoding, default sizes and the operation encoding.
package calc_pkg;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_DIGIT_MAX = 9;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit-counter width; one extra guard keeps the width legal for WIDTH < 2.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder shared by every bit position of a serial operation.
// Purely combinational.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_accum_ctrl.sv
// Bit-serial accumulate controller: accepts add/subtract requests and runs
// them LSB first through one shared full-adder cell, committing to acc.
module serial_accum_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DIGIT_MAX = DEF_DIGIT_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] op_b,
  input  logic             clear,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] acc,
  output logic             ovf,
  output logic             dec_err
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic               busy_q;
  logic               result_valid_q;
  logic [WIDTH-1:0]   acc_q;
  logic               ovf_q;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sub_q;

  logic               fa_s;
  logic               fa_cout;
  logic [WIDTH-1:0]   w_d;

  fa_cell u_fa (
    .a    (w_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // The sum bit enters at the MSB so that after WIDTH shifts the register
  // holds the full result in natural bit order.
  assign w_d = {fa_s, w_q[WIDTH-1:1]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      acc_q          <= '0;
      ovf_q          <= 1'b0;
      w_q            <= '0;
      b_q            <= '0;
      carry_q        <= 1'b0;
      cnt_q          <= '0;
      sub_q          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
          end else if (op_valid) begin
            // Subtraction is acc + ~op_b + 1: invert the operand, carry-in 1.
            w_q     <= acc_q;
            b_q     <= op_sub ? ~op_b : op_b;
            carry_q <= op_sub;
            cnt_q   <= '0;
            sub_q   <= op_sub;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end

        CALC: begin
          w_q     <= w_d;
          b_q     <= b_q >> 1;
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            acc_q          <= w_d;
            ovf_q          <= (sub_q == OP_SUB) ? ~fa_cout : fa_cout;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b1;
            state_q        <= DONE;
          end
        end

        DONE: begin
          result_valid_q <= 1'b0;
          state_q        <= IDLE;
        end

        default: begin
          busy_q         <= 1'b0;
          result_valid_q <= 1'b0;
          state_q        <= IDLE;
        end
      endcase
    end
  end

  assign op_ready     = (state_q == IDLE) && !clear;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign acc          = acc_q;
  assign ovf          = ovf_q;
  assign dec_err      = (32'(acc_q) > 32'(DIGIT_MAX));

endmodule

// File: tb/tb_serial_accum_ctrl.sv
// Self-checking bench for serial_accum_ctrl: a timing/arithmetic model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_serial_accum_ctrl;

  localparam int WIDTH     = 4;
  localparam int DIGIT_MAX = 9;
  localparam int MOD       = 1 << WIDTH;
  localparam int OP_CYCLES = WIDTH + 2;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b1;
  logic             op_valid = 1'b0;
  logic             op_sub   = 1'b0;
  logic             clear    = 1'b0;
  logic [WIDTH-1:0] op_b     = '0;
  logic             op_ready;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] acc;
  logic             ovf;
  logic             dec_err;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  serial_accum_ctrl #(
    .WIDTH     (WIDTH),
    .DIGIT_MAX (DIGIT_MAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_sub       (op_sub),
    .op_b         (op_b),
    .clear        (clear),
    .busy         (busy),
    .result_valid (result_valid),
    .acc          (acc),
    .ovf          (ovf),
    .dec_err      (dec_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: m_k counts edges since the accepting edge (-1 = idle).
  // The result is computed with plain modular arithmetic and lands on edge WIDTH.
  int m_k   = -1;
  int m_acc = 0;
  int m_ovf = 0;
  int m_b   = 0;
  bit m_sub = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k   <= -1;
      m_acc <= 0;
      m_ovf <= 0;
    end else if (m_k < 0) begin
      if (clear) begin
        m_acc <= 0;
        m_ovf <= 0;
      end else if (op_valid) begin
        m_k   <= 0;
        m_b   <= int'(op_b);
        m_sub <= op_sub;
      end
    end else if (m_k == WIDTH) begin
      m_k <= -1;
    end else begin
      m_k <= m_k + 1;
      if (m_k == WIDTH - 1) begin
        if (m_sub) begin
          m_acc <= (m_acc - m_b + MOD) % MOD;
          m_ovf <= (m_acc < m_b) ? 1 : 0;
        end else begin
          m_acc <= (m_acc + m_b) % MOD;
          m_ovf <= (m_acc + m_b >= MOD) ? 1 : 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy",     32'(busy),         32'((m_k >= 0 && m_k < WIDTH) ? 1 : 0));
      check("rvalid",   32'(result_valid), 32'((m_k == WIDTH) ? 1 : 0));
      check("op_ready", 32'(op_ready),     32'((m_k < 0 && !clear) ? 1 : 0));
      check("acc",      32'(acc),          32'(m_acc));
      check("ovf",      32'(ovf),          32'(m_ovf));
      check("dec_err",  32'(dec_err),      32'((m_acc > DIGIT_MAX) ? 1 : 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || result_valid) && n < 20) begin
      tick();
      n++;
    end
    check("wait_idle_bound", 32'(n < 20), 32'd1);
  endtask

  task automatic wait_result(output int n, output int nb);
    n  = 0;
    nb = 0;
    while (!result_valid && n < 20) begin
      if (busy) nb++;
      tick();
      n++;
    end
  endtask

  task automatic run_op(input bit sub, input int b, input int e_acc, input int e_ovf,
                        input int e_dec, input string tag);
    int n;
    int nb;
    wait_idle();
    op_valid = 1'b1;
    op_sub   = sub;
    op_b     = WIDTH'(b);
    tick();
    op_valid = 1'b0;
    wait_result(n, nb);
    check({tag, "_latency"}, 32'(n), 32'(WIDTH));
    check({tag, "_busy_cycles"}, 32'(nb), 32'(WIDTH));
    check({tag, "_acc"}, 32'(acc), 32'(e_acc));
    check({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
    check({tag, "_dec_err"}, 32'(dec_err), 32'(e_dec));
  endtask

  task automatic do_clear();
    wait_idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic set_acc(input int v);
    do_clear();
    if (v != 0) run_op(1'b0, v, v, 0, (v > DIGIT_MAX) ? 1 : 0, "preload");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int nb;
    int cyc;
    int seen;
    int accepts[$];

    #1 rst_n = 1'b0;
    #2;
    check("rst_busy",     32'(busy),         32'd0);
    check("rst_rvalid",   32'(result_valid), 32'd0);
    check("rst_acc",      32'(acc),          32'd0);
    check("rst_ovf",      32'(ovf),          32'd0);
    check("rst_dec_err",  32'(dec_err),      32'd0);
    check("rst_op_ready", 32'(op_ready),     32'd1);
    clear = 1'b1;
    #1 check("rst_ready_clear", 32'(op_ready), 32'd0);
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;

    run_op(1'b0, 5, 5, 0, 0, "add5");

    set_acc(9);
    run_op(1'b0, 8, 1, 1, 0, "9p8");
    set_acc(9);
    run_op(1'b0, 3, 12, 0, 1, "9p3");

    set_acc(3);
    run_op(1'b1, 5, 14, 1, 1, "3m5");
    set_acc(7);
    run_op(1'b1, 2, 5, 0, 0, "7m2");
    do_clear();
    run_op(1'b1, 0, 0, 0, 0, "0m0");

    // clear and a request in the same IDLE cycle: clear wins, add follows.
    set_acc(5);
    wait_idle();
    clear    = 1'b1;
    op_valid = 1'b1;
    op_sub   = 1'b0;
    op_b     = WIDTH'(4);
    #1 check("clrpri_ready", 32'(op_ready), 32'd0);
    tick();
    clear = 1'b0;
    check("clrpri_acc0", 32'(acc), 32'd0);
    check("clrpri_idle", 32'(busy), 32'd0);
    tick();
    op_valid = 1'b0;
    check("clrpri_accepted", 32'(busy), 32'd1);
    wait_result(n, nb);
    check("clrpri_acc4", 32'(acc), 32'd4);

    // Requester holds op_valid while op_b changes every cycle.
    wait_idle();
    op_valid = 1'b1;
    for (cyc = 0; cyc < 40; cyc++) begin
      op_b   = WIDTH'($urandom);
      op_sub = 1'($urandom);
      #1;
      if (op_ready) accepts.push_back(cyc);
      tick();
    end
    op_valid = 1'b0;
    check("held_accept_count", 32'(accepts.size() >= 6), 32'd1);
    for (int i = 1; i < accepts.size(); i++)
      check("held_accept_spacing", 32'(accepts[i] - accepts[i-1]), 32'(OP_CYCLES));

    // Reset during the second CALC cycle aborts the add of 6 onto 3.
    set_acc(3);
    wait_idle();
    op_valid = 1'b1;
    op_sub   = 1'b0;
    op_b     = WIDTH'(6);
    tick();
    op_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_acc",    32'(acc),          32'd0);
    check("abort_busy",   32'(busy),         32'd0);
    check("abort_rvalid", 32'(result_valid), 32'd0);
    check("abort_ready",  32'(op_ready),     32'd1);
    tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      tick();
      if (result_valid) seen++;
    end
    check("abort_no_pulse", 32'(seen), 32'd0);

    // Random traffic with occasional clears, checked by the model each cycle.
    repeat (400) begin
      op_valid = 1'($urandom);
      op_sub   = 1'($urandom);
      op_b     = WIDTH'($urandom);
      clear    = ($urandom_range(0, 5) == 0);
      tick();
    end
    op_valid = 1'b0;
    clear    = 1'b0;
    repeat (OP_CYCLES + 2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
